// File: rtl/out_argmax.sv
// rtl/out_argmax.sv - serial argmax over NN layer scores with valid/ack result handshake
// Optional score readback bank: define OUT_ARGMAX_SCORE_BANK_EN.
module out_argmax #(
    parameter int DATA_WIDTH = 29,
    parameter int NN         = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  layer_done_in,
    input  logic                  transferred_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  shift_out,
    output logic                  restart_out,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic [DATA_WIDTH-1:0] max_score,
    output logic                  busy,
    input  logic [IDX_WIDTH-1:0]  score_sel,
    output logic [DATA_WIDTH-1:0] score_rd
);

    typedef enum logic [1:0] {IDLE, SHIFT, RELEASE, DONE} state_t;

    state_t                state_q;
    logic [IDX_WIDTH-1:0]  cnt_q;
    logic                  armed_q;
    logic                  shift_q;
    logic                  restart_q;
    logic                  valid_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] max_q;

    logic start;
    logic last;
    logic take;

    // armed_q blocks a stale layer_done_in from retriggering until it has been seen low
    assign start = (state_q == IDLE) && layer_done_in && armed_q;
    assign last  = (cnt_q == IDX_WIDTH'(NN - 1));
    assign take  = (cnt_q == '0) || ($signed(data_in) > $signed(max_q));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            shift_q   <= 1'b0;
            restart_q <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            max_q     <= '0;
        end else begin
            if (!layer_done_in) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        max_q   <= '0;
                        idx_q   <= '0;
                        shift_q <= 1'b1;
                        armed_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (take) begin
                        max_q <= data_in;
                        idx_q <= cnt_q;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        shift_q   <= 1'b0;
                        restart_q <= 1'b1;
                        state_q   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!transferred_in) begin
                        restart_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shift_out    = shift_q;
    assign restart_out  = restart_q;
    assign result_valid = valid_q;
    assign class_idx    = idx_q;
    assign max_score    = max_q;
    assign busy         = (state_q != IDLE);

`ifdef OUT_ARGMAX_SCORE_BANK_EN
    logic [DATA_WIDTH-1:0] bank_q [NN];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NN; i++) begin
                bank_q[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < NN; i++) begin
                bank_q[i] <= '0;
            end
        end else if (state_q == SHIFT) begin
            bank_q[cnt_q] <= data_in;
        end
    end

    assign score_rd = ({1'b0, score_sel} < (IDX_WIDTH + 1)'(NN)) ? bank_q[score_sel] : '0;
`else
    logic unused_score_sel;
    assign unused_score_sel = ^score_sel;
    assign score_rd         = '0;
`endif

endmodule

// File: doc/out_argmax.md
# out_argmax

Output-classification stage directly downstream of the last hidden/output neuron layer. It waits for the layer's all-neurons-finished flag, then drives the layer's shift strobe to serially unload its NN signed fixed-point scores. It tracks the running maximum, and presents the winning class index and score with a valid/ack handshake. Finally it pulses the layer's restart so the layer returns to its idle state for the next inference.

## Interface
- `DATA_WIDTH`, 29: width of one serial score word (layer input width + 3), two's complement.
- `NN`, 10: number of scores unloaded per inference.
- `IDX_WIDTH`, 4: width of class index; must satisfy 2^IDX_WIDTH >= NN.

- `clk`  in  1: single clock; all state on rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `layer_done_in`  in  1: upstream all-neurons-finished flag.
- `transferred_in`  in  1: upstream flag, high once all NN words are shifted out.
- `data_in`  in  DATA_WIDTH: upstream serial score word.
- `shift_out`  out  1: shift strobe to upstream.
- `restart_out`  out  1: restart request to upstream.
- `result_valid`  out  1: class result available.
- `result_ack`  in  1: consumer accepts result.
- `class_idx`  out  IDX_WIDTH: index (0..NN-1) of the maximum score.
- `max_score`  out  DATA_WIDTH: maximum score value.
- `busy`  out  1: high in any state other than IDLE.
- `score_sel`  in  IDX_WIDTH: score readback select (see Configuration).
- `score_rd`  out  DATA_WIDTH: score readback data.

## Operation
- States: IDLE, SHIFT, RELEASE, DONE.
- Reset: state IDLE; all outputs 0; counter 0; score bank 0.
- IDLE: on `layer_done_in`=1, go to SHIFT, set counter=0, and clear `max_score`/`class_idx`.
- SHIFT: `shift_out`=1 for exactly NN consecutive cycles.
  - Upstream updates `data_in` on the falling edge inside each strobe cycle.
  - This block samples `data_in` on the rising edge that ends that cycle. Sample k is score k.
  - Comparison is signed over DATA_WIDTH bits. Sample 0 is loaded unconditionally.
  - Sample k (k>0) replaces the held max only if strictly greater. On a tie, the lowest index wins.
  - After sample NN-1, go to RELEASE.
- RELEASE: `restart_out`=1 while `transferred_in`=1.
  - Once `transferred_in` is sampled 0, drop `restart_out` and go to DONE.
- DONE: `result_valid`=1; `class_idx` and `max_score` are held stable.
  - On `result_ack`=1, clear `result_valid` and go to IDLE.
  - `layer_done_in` is ignored until IDLE is re-entered with `layer_done_in` having been seen low at least one cycle. This prevents double-triggering on a stale flag.
- `busy` = (state != IDLE).
- `rstn` low mid-operation aborts immediately.
  - All outputs go to 0 asynchronously.
  - Upstream is not restarted by this block; the system reset covers it.

## Timing
- Latency from `layer_done_in` sampled high to `shift_out` high: 1 cycle.
- `shift_out` high for exactly NN cycles (10 at default); never gapped.
- `restart_out` asserts on the cycle after the last strobe cycle.
  - Minimum RELEASE duration is 1 cycle. It lasts longer if upstream holds `transferred_in`.
- `result_valid` asserts on the cycle after `restart_out` deasserts.
  - Minimum done-to-valid is NN+2 cycles.
- `result_ack` held high in DONE: result consumed in 1 cycle; `result_valid` low on the next edge.
- `result_ack` outside DONE is ignored.
- `shift_out` and `restart_out` are never high in the same cycle.

## Configuration
- `OUT_ARGMAX_SCORE_BANK_EN`
  - Defined: every sampled score is also written into an NN x DATA_WIDTH register bank. `score_rd` = bank[`score_sel`] combinationally, valid in DONE. Out-of-range `score_sel` (>=NN) returns 0. The bank is cleared on reset and on entry to SHIFT.
  - Undefined: no bank is built; `score_rd` is tied to 0. `score_sel` is unused.

## Test plan
- Scores 0..9 = {5,3,9,1,9,0,-2,7,8,2}: `layer_done_in` -> `shift_out` high 10 cycles, then `class_idx`=2, `max_score`=9 (first of the tied 9s), `result_valid`=1.
- All scores equal -4 (negative): `class_idx`=0, `max_score`=-4. Verifies signed compare and the tie rule.
- Max at last position (score 9 = 0x0FFFFFFF, others 0): `class_idx`=9. Verifies final sample capture and no extra strobe (exactly 10).
- Upstream holds `transferred_in` high 3 cycles into RELEASE: `restart_out` high until `transferred_in` falls, then `result_valid`=1 on the next cycle; no strobe during RELEASE.
- Assert `rstn`=0 in cycle 4 of SHIFT: all outputs 0 asynchronously. After release with `layer_done_in`=1, a fresh 10-strobe sequence runs and returns the correct result.
- With `OUT_ARGMAX_SCORE_BANK_EN`, scores as in test 1: `score_sel`=7 -> `score_rd`=7; `score_sel`=12 -> 0. Without the macro: `score_rd`=0 always.
